// File: rtl/rat_move_step_unit.sv
`default_nettype none
// ============================================================================
// Module   : rat_move_step_unit
// Brief    : Maze-rat step adder with grid-edge detection, next X/Y muxing
//            and the 2-bit direction counter used by the controller.
// Revision : 1.0 - initial release
// ============================================================================
module rat_move_step_unit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cur_x,
    input  logic [WIDTH-1:0] cur_y,
    input  logic             adder_sel,
    input  logic             inc_dec_sel,
    input  logic             x_sel,
    input  logic             y_sel,
    output logic [WIDTH-1:0] adder_res,
    output logic             cout,
    output logic             out_of_range,
    output logic [WIDTH-1:0] next_x,
    output logic [WIDTH-1:0] next_y,
    input  logic             rst_counter,
    input  logic             ld_counter,
    input  logic             inc_counter,
    input  logic [CNT_W-1:0] counter_ld_val,
    output logic [CNT_W-1:0] counter_val,
    output logic             co
);

    localparam logic [WIDTH-1:0] c_step_inc = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_step_dec = {WIDTH{1'b1}};

    logic [WIDTH-1:0] w_operand;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH:0]   w_sum;
    logic [CNT_W-1:0] r_counter;

    assign w_operand = adder_sel ? cur_x : cur_y;
    assign w_step    = inc_dec_sel ? c_step_inc : c_step_dec;
    assign w_sum     = {1'b0, w_operand} + {1'b0, w_step};

    assign adder_res = w_sum[WIDTH-1:0];
    assign cout      = w_sum[WIDTH];

    // Adding -1 as all-ones carries out for every operand except 0, so a
    // missing carry on decrement means the step went below the grid.
    assign out_of_range = (inc_dec_sel & cout) | (~inc_dec_sel & ~cout);

    assign next_x = x_sel ? adder_res : cur_x;
    assign next_y = y_sel ? adder_res : cur_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_counter <= '0;
        end else if (rst_counter) begin
            r_counter <= '0;
        end else if (ld_counter) begin
            r_counter <= counter_ld_val;
        end else if (inc_counter) begin
            r_counter <= r_counter + CNT_W'(1);
        end
    end

    assign counter_val = r_counter;
    assign co          = &r_counter;

endmodule
`default_nettype wire

// File: tb/tb_rat_move_step_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rat_move_step_unit
// Brief    : Directed vectors with a queue-based scoreboard for the step unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rat_move_step_unit;

    logic       clk;
    logic       rst;
    logic [3:0] cur_x, cur_y;
    logic       adder_sel, inc_dec_sel, x_sel, y_sel;
    logic [3:0] adder_res, next_x, next_y;
    logic       cout, out_of_range;
    logic       rst_counter, ld_counter, inc_counter;
    logic [1:0] counter_ld_val, counter_val;
    logic       co;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic       rst;
        logic [3:0] cx, cy;
        logic       asel, ids, xs, ys;
        logic       rc, ld, inc;
        logic [1:0] ldv;
        logic [3:0] e_ar;
        logic       e_cout, e_oor;
        logic [3:0] e_nx, e_ny;
        logic [1:0] e_cv;
        logic       e_co;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] ar;
        logic       cout, oor;
        logic [3:0] nx, ny;
        logic [1:0] cv;
        logic       co;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    rat_move_step_unit #(.WIDTH(4), .CNT_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .cur_x          (cur_x),
        .cur_y          (cur_y),
        .adder_sel      (adder_sel),
        .inc_dec_sel    (inc_dec_sel),
        .x_sel          (x_sel),
        .y_sel          (y_sel),
        .adder_res      (adder_res),
        .cout           (cout),
        .out_of_range   (out_of_range),
        .next_x         (next_x),
        .next_y         (next_y),
        .rst_counter    (rst_counter),
        .ld_counter     (ld_counter),
        .inc_counter    (inc_counter),
        .counter_ld_val (counter_ld_val),
        .counter_val    (counter_val),
        .co             (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int idx, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fails++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, expv);
        end
    endfunction

    function automatic vec_t mk(
        logic r, logic [3:0] cx, logic [3:0] cy, logic asel, logic ids, logic xs, logic ys,
        logic rc, logic ld, logic inc, logic [1:0] ldv,
        logic [3:0] ar, logic c, logic oor, logic [3:0] nx, logic [3:0] ny, logic [1:0] cv, logic cco);
        vec_t v;
        v.rst = r; v.cx = cx; v.cy = cy; v.asel = asel; v.ids = ids; v.xs = xs; v.ys = ys;
        v.rc = rc; v.ld = ld; v.inc = inc; v.ldv = ldv;
        v.e_ar = ar; v.e_cout = c; v.e_oor = oor; v.e_nx = nx; v.e_ny = ny; v.e_cv = cv; v.e_co = cco;
        return v;
    endfunction

    // Monitor: outputs are combinational, so every falling edge presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("adder_res",    e.idx, int'(adder_res),    int'(e.ar));
                chk("cout",         e.idx, int'(cout),         int'(e.cout));
                chk("out_of_range", e.idx, int'(out_of_range), int'(e.oor));
                chk("next_x",       e.idx, int'(next_x),       int'(e.nx));
                chk("next_y",       e.idx, int'(next_y),       int'(e.ny));
                chk("counter_val",  e.idx, int'(counter_val),  int'(e.cv));
                chk("co",           e.idx, int'(co),           int'(e.co));
            end
        end
    end

    initial begin
        #5000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        //          rst cx  cy  as id xs ys rc ld in ldv  ar  c  oor nx  ny  cv co
        vecs.push_back(mk(0,  5,  9, 1, 1, 1, 0, 0, 0, 0, 0,  6, 0, 0,  6,  9, 0, 0));
        vecs.push_back(mk(1, 15,  9, 1, 1, 1, 0, 0, 0, 1, 0,  0, 1, 1,  0,  9, 0, 0));
        vecs.push_back(mk(1, 15,  0, 0, 0, 0, 1, 0, 0, 1, 0, 15, 0, 1, 15, 15, 1, 0));
        vecs.push_back(mk(1,  3,  7, 0, 0, 1, 1, 0, 0, 1, 0,  6, 1, 0,  6,  6, 2, 0));
        vecs.push_back(mk(1,  0,  4, 1, 1, 0, 0, 0, 0, 1, 0,  1, 0, 0,  0,  4, 3, 1));
        vecs.push_back(mk(1,  8, 12, 1, 0, 1, 0, 0, 0, 0, 0,  7, 1, 0,  7, 12, 0, 0));
        vecs.push_back(mk(1,  2, 15, 0, 1, 0, 1, 0, 1, 1, 2,  0, 1, 1,  2,  0, 0, 0));
        vecs.push_back(mk(1,  1,  5, 1, 0, 1, 1, 1, 1, 0, 3,  0, 1, 0,  0,  0, 2, 0));
        vecs.push_back(mk(1,  0,  3, 1, 0, 1, 0, 0, 1, 0, 3, 15, 0, 1, 15,  3, 0, 0));
        vecs.push_back(mk(1, 10, 14, 0, 1, 0, 1, 0, 1, 0, 3, 15, 0, 0, 10, 15, 3, 1));
        vecs.push_back(mk(1, 15,  1, 1, 0, 0, 0, 0, 0, 0, 0, 14, 1, 0, 15,  1, 3, 1));
        vecs.push_back(mk(1,  4,  8, 0, 1, 1, 0, 0, 0, 0, 0,  9, 0, 0,  9,  8, 3, 1));
        // Reset dropped between edges while the counter holds 3.
        vecs.push_back(mk(0,  7,  2, 1, 1, 0, 1, 0, 0, 1, 0,  8, 0, 0,  7,  8, 0, 0));
        vecs.push_back(mk(1,  9,  1, 0, 0, 1, 1, 0, 0, 1, 0,  0, 1, 0,  0,  0, 0, 0));
        vecs.push_back(mk(1, 14,  0, 1, 1, 1, 0, 0, 0, 0, 0, 15, 0, 0, 15,  0, 1, 0));

        rst = 1'b0;
        cur_x = '0; cur_y = '0;
        adder_sel = 1'b0; inc_dec_sel = 1'b0; x_sel = 1'b0; y_sel = 1'b0;
        rst_counter = 1'b0; ld_counter = 1'b0; inc_counter = 1'b0; counter_ld_val = '0;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst            = vecs[i].rst;
            cur_x          = vecs[i].cx;
            cur_y          = vecs[i].cy;
            adder_sel      = vecs[i].asel;
            inc_dec_sel    = vecs[i].ids;
            x_sel          = vecs[i].xs;
            y_sel          = vecs[i].ys;
            rst_counter    = vecs[i].rc;
            ld_counter     = vecs[i].ld;
            inc_counter    = vecs[i].inc;
            counter_ld_val = vecs[i].ldv;
            e.idx = i;
            e.ar = vecs[i].e_ar; e.cout = vecs[i].e_cout; e.oor = vecs[i].e_oor;
            e.nx = vecs[i].e_nx; e.ny = vecs[i].e_ny; e.cv = vecs[i].e_cv; e.co = vecs[i].e_co;
            exp_q.push_back(e);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drain", -1, exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
